// File: rtl/encoder_frame_scheduler_if.sv
// Byte-level transmit bus between the frame scheduler and the UART TX.
// The scheduler is the master; it offers tx_data/tx_valid and the UART
// answers with tx_ready.
interface encoder_frame_scheduler_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/encoder_frame_scheduler.sv
// encoder_frame_scheduler
// Packs the rotary-encoder counters into one telemetry frame per rising edge
// of trig: SYNC_BYTE, one byte per channel (channel 0 first), then an XOR
// checksum of the channel bytes. All counters are snapshotted when the frame
// starts, so counter activity during the burst never tears the frame.
// One request arriving while a frame is in flight is remembered and served
// right after it; further requests are dropped.
//
// Optional build macro ENC_FRAME_SEQ_EN: inserts an 8-bit wrapping frame
// sequence byte after SYNC_BYTE. That byte is covered by the checksum.
module encoder_frame_scheduler #(
  parameter int         NUM_CH    = 12,
  parameter int         CNT_W     = 5,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      trig,
  input  logic [NUM_CH*CNT_W-1:0]   cnt_flat,
  encoder_frame_scheduler_if.master tx,
  output logic                      busy,
  output logic                      frame_done
);

`ifdef ENC_FRAME_SEQ_EN
  typedef enum logic [2:0] {IDLE, SYNC, SEQ, DATA, CSUM, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, SYNC, DATA, CSUM, DONE} state_t;
`endif

  localparam logic [3:0] LAST_IDX = 4'(NUM_CH - 1);

  state_t           state;
  logic             trig_q;
  logic             pending;
  logic [CNT_W-1:0] shadow [NUM_CH];
  logic [3:0]       ch_idx;
  logic [7:0]       csum;
  logic [7:0]       tx_data_q;
  logic             tx_valid_q;
`ifdef ENC_FRAME_SEQ_EN
  logic [7:0]       seq_cnt;
`endif

  logic             trig_rise;
  logic             accept;
  logic [7:0]       data_byte;

  assign trig_rise   = trig & ~trig_q;
  assign accept      = tx_valid_q & tx.tx_ready;
  assign tx.tx_data  = tx_data_q;
  assign tx.tx_valid = tx_valid_q;

  // Select the snapshotted channel addressed by ch_idx, zero-extended to a byte.
  always_comb begin
    // NOTE: default assignment first so no path through the loop leaves data_byte unassigned (no latch).
    data_byte = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ch_idx == 4'(k)) data_byte = 8'(shadow[k]);
    end
  end

  // Frame sequencer: edge detect, request queueing, snapshot and byte handshake.
  // Each byte is loaded one cycle after the previous accept (tx_valid low in
  // between), giving at most one byte per two cycles.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      trig_q     <= 1'b0;
      pending    <= 1'b0;
      ch_idx     <= '0;
      csum       <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      // NOTE: the shadow bank is a small flop array rather than a RAM, so it takes a reset like any other register.
      for (int k = 0; k < NUM_CH; k++) shadow[k] <= '0;
`ifdef ENC_FRAME_SEQ_EN
      seq_cnt    <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments throughout, so every read below sees the pre-edge value.
      trig_q <= trig;

      case (state)
        IDLE: begin
          if (trig_rise || pending) begin
            state      <= SYNC;
            pending    <= 1'b0;
            ch_idx     <= '0;
            csum       <= '0;
            tx_data_q  <= SYNC_BYTE;
            tx_valid_q <= 1'b1;
            busy       <= 1'b1;
            for (int k = 0; k < NUM_CH; k++) shadow[k] <= cnt_flat[k*CNT_W +: CNT_W];
          end
        end

        SYNC: begin
          if (accept) begin
            tx_valid_q <= 1'b0;
`ifdef ENC_FRAME_SEQ_EN
            state      <= SEQ;
`else
            state      <= DATA;
`endif
          end
        end

`ifdef ENC_FRAME_SEQ_EN
        SEQ: begin
          if (!tx_valid_q) begin
            tx_data_q  <= seq_cnt;
            tx_valid_q <= 1'b1;
          end else if (accept) begin
            csum       <= csum ^ seq_cnt;
            tx_valid_q <= 1'b0;
            state      <= DATA;
          end
        end
`endif

        DATA: begin
          if (!tx_valid_q) begin
            tx_data_q  <= data_byte;
            tx_valid_q <= 1'b1;
          end else if (accept) begin
            csum       <= csum ^ tx_data_q;
            tx_valid_q <= 1'b0;
            if (ch_idx == LAST_IDX) state  <= CSUM;
            else                    ch_idx <= ch_idx + 4'd1;
          end
        end

        CSUM: begin
          if (!tx_valid_q) begin
            tx_data_q  <= csum;
            tx_valid_q <= 1'b1;
          end else if (accept) begin
            tx_valid_q <= 1'b0;
            frame_done <= 1'b1;
            state      <= DONE;
          end
        end

        DONE: begin
          frame_done <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
`ifdef ENC_FRAME_SEQ_EN
          seq_cnt    <= seq_cnt + 8'd1;
`endif
        end

        default: state <= IDLE;
      endcase

      // A request seen outside IDLE (DONE included) is held for one more frame.
      if (state != IDLE && trig_rise) pending <= 1'b1;
    end
  end

endmodule
